// File: rtl/multicycle_controller_if.sv
// Control-unit bus: run/fetch handshake, decoded opcode and flags in, datapath strobes out.
interface multicycle_controller_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 4,
  parameter int unsigned CNTW = 8
);
  logic            run;
  logic            ir_valid;
  logic [OPW-1:0]  Opcode;
  logic            Z;
  logic            C;
  logic            fetch_req;
  logic            LoadIR;
  logic            IncPC;
  logic            SelPC;
  logic            LoadPC;
  logic            LoadReg;
  logic            LoadAcc;
  logic [1:0]      SelAcc;
  logic [ALUW-1:0] SelALU;
  logic            halted;
  logic [2:0]      state;
  logic [CNTW-1:0] instr_count;

  modport master (
    output run, ir_valid, Opcode, Z, C,
    input  fetch_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
    input  SelAcc, SelALU, halted, state, instr_count
  );

  modport slave (
    input  run, ir_valid, Opcode, Z, C,
    output fetch_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
    output SelAcc, SelALU, halted, state, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: IDLE/FETCH/DECODE/EXEC/HALT sequencer with
// opcode-decoded datapath strobes and a saturating retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 4,
  parameter int unsigned CNTW = 8
) (
  input logic                     clk,
  input logic                     CLB,
  multicycle_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    EXEC   = 3'b011,
    HALT   = 3'b100
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q;
  logic            z_q, c_q;
  logic [CNTW-1:0] cnt_q;
  logic            op_hi;

  logic       fetch_req, load_ir, inc_pc, sel_pc, load_pc, load_reg, load_acc;
  logic [1:0] sel_acc;
  logic [3:0] sel_alu;

  // Any opcode bit above the 4-bit ISA field makes the instruction a NOP.
  assign op_hi = |(op_q >> 4);

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state_q <= IDLE;
      op_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q <= bus.Opcode;
        z_q  <= bus.Z;
        c_q  <= bus.C;
      end
      if (state_q == EXEC && cnt_q != {CNTW{1'b1}})
        cnt_q <= cnt_q + CNTW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    load_ir   = 1'b0;
    inc_pc    = 1'b0;
    sel_pc    = 1'b0;
    load_pc   = 1'b0;
    load_reg  = 1'b0;
    load_acc  = 1'b0;
    sel_acc   = 2'b00;
    sel_alu   = 4'b0000;
    case (state_q)
      IDLE: if (bus.run) state_d = FETCH;
      FETCH: begin
        fetch_req = 1'b1;
        if (bus.ir_valid) begin
          load_ir = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        if (op_hi) begin
          inc_pc = 1'b1;
        end else begin
          case (op_q[3:0])
            4'h1: begin sel_alu = 4'b1000; load_acc = 1'b1; inc_pc = 1'b1; end
            4'h2: begin sel_alu = 4'b1100; load_acc = 1'b1; inc_pc = 1'b1; end
            4'h3: begin sel_alu = 4'b0100; load_acc = 1'b1; inc_pc = 1'b1; end
            4'hB: begin sel_alu = 4'b0001; load_acc = 1'b1; inc_pc = 1'b1; end
            4'hC: begin sel_alu = 4'b0011; load_acc = 1'b1; inc_pc = 1'b1; end
            4'h4: begin sel_acc = 2'b01; load_acc = 1'b1; inc_pc = 1'b1; end
            4'h5: begin load_reg = 1'b1; inc_pc = 1'b1; end
            4'hD: begin sel_acc = 2'b10; load_acc = 1'b1; inc_pc = 1'b1; end
            // Conditional jumps: taken loads PC, not taken falls through.
            4'h6: begin sel_pc = 1'b1; load_pc = z_q; inc_pc = ~z_q; end
            4'h7: begin sel_pc = 1'b0; load_pc = z_q; inc_pc = ~z_q; end
            4'h8: begin sel_pc = 1'b1; load_pc = c_q; inc_pc = ~c_q; end
            4'hA: begin sel_pc = 1'b0; load_pc = c_q; inc_pc = ~c_q; end
            4'hF: state_d = HALT;
            default: inc_pc = 1'b1;
          endcase
        end
      end
      HALT: if (bus.run) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  assign bus.fetch_req   = fetch_req;
  assign bus.LoadIR      = load_ir;
  assign bus.IncPC       = inc_pc;
  assign bus.SelPC       = sel_pc;
  assign bus.LoadPC      = load_pc;
  assign bus.LoadReg     = load_reg;
  assign bus.LoadAcc     = load_acc;
  assign bus.SelAcc      = sel_acc;
  assign bus.SelALU      = ALUW'(sel_alu);
  assign bus.halted      = (state_q == HALT);
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: two controllers (wide opcode/ALU with 8-bit counter, default
// widths with 2-bit counter) checked cycle by cycle against an instruction-level model.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic CLB = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OPW(6), .ALUW(6), .CNTW(8)) bus1 ();
  multicycle_controller_if #(.OPW(4), .ALUW(4), .CNTW(2)) bus2 ();

  multicycle_controller #(.OPW(6), .ALUW(6), .CNTW(8)) dut1 (.clk(clk), .CLB(CLB), .bus(bus1));
  multicycle_controller #(.OPW(4), .ALUW(4), .CNTW(2)) dut2 (.clk(clk), .CLB(CLB), .bus(bus2));

  // Wide opcodes with upper bits set are NOPs; the narrow DUT sees opcode 0000 instead.
  assign bus2.run      = bus1.run;
  assign bus2.ir_valid = bus1.ir_valid;
  assign bus2.Z        = bus1.Z;
  assign bus2.C        = bus1.C;
  assign bus2.Opcode   = (bus1.Opcode[5:4] != 2'b00) ? 4'h0 : bus1.Opcode[3:0];

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 idle, 1 fetch, 2 decode, 3 exec, 4 halt (spec encodings).
  int         m_state = 0;
  logic [5:0] m_op = '0;
  logic       m_z = 1'b0, m_c = 1'b0;
  int         m_cnt = 0, m_cnt2 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected EXEC strobes {fetch,ldir,inc,selpc,ldpc,ldreg,ldacc,selacc[1:0],selalu[5:0]}.
  function automatic logic [14:0] exp_exec(input logic [5:0] op, input logic z, input logic c);
    logic inc, spc, lpc, lreg, lacc, flag;
    logic [1:0] sacc;
    logic [5:0] alu;
    inc = 0; spc = 0; lpc = 0; lreg = 0; lacc = 0; sacc = 2'b00; alu = '0; flag = 0;
    if (op[5:4] != 2'b00) inc = 1;
    else case (op[3:0])
      4'h1, 4'h2, 4'h3, 4'hB, 4'hC: begin
        lacc = 1; inc = 1;
        alu = (op[3:0] == 4'h1) ? 6'b001000 : (op[3:0] == 4'h2) ? 6'b001100 :
              (op[3:0] == 4'h3) ? 6'b000100 : (op[3:0] == 4'hB) ? 6'b000001 : 6'b000011;
      end
      4'h4: begin sacc = 2'b01; lacc = 1; inc = 1; end
      4'h5: begin lreg = 1; inc = 1; end
      4'hD: begin sacc = 2'b10; lacc = 1; inc = 1; end
      4'h6, 4'h7, 4'h8, 4'hA: begin
        flag = (op[3:0] <= 4'h7) ? z : c;
        spc  = (op[3:0] == 4'h6) || (op[3:0] == 4'h8);
        if (flag) lpc = 1; else inc = 1;
      end
      4'hF: ;
      default: inc = 1;
    endcase
    return {1'b0, 1'b0, inc, spc, lpc, lreg, lacc, sacc, alu};
  endfunction

  task automatic compare_all();
    logic [14:0] e, o1, o2;
    case (m_state)
      1: e = {1'b1, bus1.ir_valid, 13'b0};
      3: e = exp_exec(m_op, m_z, m_c);
      default: e = '0;
    endcase
    o1 = {bus1.fetch_req, bus1.LoadIR, bus1.IncPC, bus1.SelPC, bus1.LoadPC, bus1.LoadReg,
          bus1.LoadAcc, bus1.SelAcc, bus1.SelALU};
    o2 = {bus2.fetch_req, bus2.LoadIR, bus2.IncPC, bus2.SelPC, bus2.LoadPC, bus2.LoadReg,
          bus2.LoadAcc, bus2.SelAcc, 2'b00, bus2.SelALU};
    check_eq("state",    32'(bus1.state), 32'(m_state));
    check_eq("strobes",  32'(o1), 32'(e));
    check_eq("halted",   32'(bus1.halted), 32'(m_state == 4));
    check_eq("count",    32'(bus1.instr_count), 32'(m_cnt));
    check_eq("state2",   32'(bus2.state), 32'(m_state));
    check_eq("strobes2", 32'(o2), 32'(e));
    check_eq("halted2",  32'(bus2.halted), 32'(m_state == 4));
    check_eq("count2",   32'(bus2.instr_count), 32'(m_cnt2));
  endtask

  task automatic advance_model();
    case (m_state)
      0: if (bus1.run) m_state = 1;
      1: if (bus1.ir_valid) m_state = 2;
      2: begin m_op = bus1.Opcode; m_z = bus1.Z; m_c = bus1.C; m_state = 3; end
      3: begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        m_state = (m_op == 6'h0F) ? 4 : 1;
      end
      default: if (bus1.run) m_state = 1;
    endcase
  endtask

  task automatic model_reset();
    m_state = 0; m_op = '0; m_z = 0; m_c = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // One clock: drive inputs just after the rising edge, check at the falling edge.
  task automatic cycle(input logic r, input logic iv, input logic [5:0] op,
                       input logic z, input logic c);
    bus1.run = r; bus1.ir_valid = iv; bus1.Opcode = op; bus1.Z = z; bus1.C = c;
    @(negedge clk);
    compare_all();
    advance_model();
    @(posedge clk); #1;
  endtask

  task automatic goto_fetch();
    int n;
    n = 0;
    while (m_state != 1 && n < 10) begin
      cycle(1'b1, 1'b1, 6'h00, 1'b0, 1'b0);
      n++;
    end
    check_eq("goto_fetch", 32'(bus1.state), 32'd1);
  endtask

  // Async reset pulse inside an EXEC cycle, released before the next edge.
  task automatic reset_pulse();
    bus1.run = 1; bus1.ir_valid = 1; bus1.Opcode = 6'h00; bus1.Z = 0; bus1.C = 0;
    #1;
    compare_all();
    CLB = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 CLB = 1'b1;
    @(negedge clk);
    compare_all();
    advance_model();
    @(posedge clk); #1;
  endtask

  initial begin
    bus1.run = 1; bus1.ir_valid = 1; bus1.Opcode = 6'h01; bus1.Z = 0; bus1.C = 0;
    @(posedge clk); #1;
    compare_all();
    @(posedge clk); #1;
    CLB = 1'b1;

    repeat (3) cycle(1'b0, 1'b1, 6'h01, 1'b0, 1'b0);
    repeat (15) cycle(1'b1, 1'b1, 6'h01, 1'b0, 1'b0);

    goto_fetch();
    repeat (5) cycle(1'b1, 1'b0, 6'h01, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 6'h01, 1'b0, 1'b0);

    for (int k = 0; k < 2; k++) begin
      goto_fetch();
      cycle(1'b1, 1'b1, 6'h07, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 6'h07, (k == 0), (k == 0));
      cycle(1'b1, 1'b1, 6'h07, (k != 0), (k != 0));
    end

    goto_fetch();
    cycle(1'b1, 1'b1, 6'h0F, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 6'h0F, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 6'h0F, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b1, 6'h0F, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 6'h0F, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 6'h0F, 1'b0, 1'b0);

    goto_fetch();
    cycle(1'b1, 1'b1, 6'h05, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 6'h05, 1'b0, 1'b0);
    reset_pulse();

    for (int i = 0; i < 600; i++) begin
      logic [5:0] op;
      op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) op[5:4] = 2'b00;
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), op,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter OPW, default 4, opcode width; SHALL be >= 4.
REQ-002 Parameter ALUW, default 4, SelALU width; SHALL be >= 4; ALU codes occupy bits [3:0], upper bits driven 0.
REQ-003 Parameter CNTW, default 8, retired-instruction counter width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 CLB  input  1  asynchronous active-low reset.
REQ-006 run  input  1  start/resume request, level-sampled.
REQ-007 ir_valid  input  1  instruction memory acknowledge for fetch_req.
REQ-008 Opcode  input  OPW  opcode field from IR, valid in DECODE.
REQ-009 Z, C  input  1 each  zero/carry flags from ALU.
REQ-010 fetch_req  output  1  instruction fetch request.
REQ-011 LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc  output  1 each  datapath strobes.
REQ-012 SelAcc  output  2  accumulator source: 00 ALU, 01 register, 10 immediate.
REQ-013 SelALU  output  ALUW  ALU op/shift select.
REQ-014 halted  output  1  high while in HALT.
REQ-015 state  output  3  current state encoding: IDLE 000, FETCH 001, DECODE 010, EXEC 011, HALT 100.
REQ-016 instr_count  output  CNTW  retired instructions, saturating.

Function
REQ-017 IDLE: all strobes 0; run=1 -> FETCH next cycle, else stay.
REQ-018 FETCH: fetch_req=1 every cycle; ir_valid=0 -> stay (unbounded wait); ir_valid=1 -> LoadIR=1 that same cycle, next DECODE.
REQ-019 DECODE: one cycle; latch Opcode, Z, C into internal registers; all strobes 0; next EXEC.
REQ-020 EXEC: one cycle; strobes driven combinationally from latched opcode/flags per REQ-021..026; next FETCH, except HALT opcode -> HALT.
REQ-021 ALU ops: 0001 ADD SelALU=1000, 0010 SUB 1100, 0011 NOR 0100, 1011 SHL 0001, 1100 SHR 0011; each with SelAcc=00, LoadAcc=1, IncPC=1.
REQ-022 Moves: 0100 SelAcc=01, LoadAcc=1, IncPC=1; 0101 LoadReg=1, IncPC=1; 1101 load immediate SelAcc=10, LoadAcc=1, IncPC=1.
REQ-023 Jumps: 0110 (Z, reg target SelPC=1), 0111 (Z, immediate SelPC=0), 1000 (C, reg SelPC=1), 1010 (C, immediate SelPC=0); flag=1 -> LoadPC=1, IncPC=0; flag=0 -> IncPC=1, LoadPC=0.
REQ-024 NOP: 0000, 1001, 1110, and any opcode with a bit above bit 3 set -> IncPC=1 only.
REQ-025 HALT 1111: no strobes; next HALT.
REQ-026 Strobes not listed for an opcode SHALL be 0; LoadPC and IncPC never both 1; every strobe high for exactly one cycle per instruction.
REQ-027 instr_count increments by 1 on each EXEC cycle, including HALT; holds at all-ones (no wrap).
REQ-028 HALT: halted=1, strobes 0; run=1 -> FETCH next cycle (PC not advanced, so HALT refetches unless PC externally changed).
REQ-029 Encodings 101-111 unreachable; if entered, next state IDLE.
REQ-030 Flags sampled only in DECODE; flag changes during EXEC SHALL not alter strobes.

Reset
REQ-031 CLB=0 asynchronously forces state IDLE, all strobes, SelAcc, SelALU, fetch_req, halted, latched opcode/flags and instr_count to 0, regardless of state or pending fetch.
REQ-032 After CLB deasserts, first transition occurs on the next rising clk with run=1.

Verification
REQ-033 Reset, run=1, ir_valid=1 constant, Opcode=0001 -> states 001,010,011 repeating; EXEC cycle SelALU=1000, LoadAcc=1, IncPC=1; instr_count 1,2,3.
REQ-034 FETCH with ir_valid held 0 for 5 cycles -> fetch_req=1 for 6 cycles, LoadIR=1 only on the 6th.
REQ-035 Opcode=0111, Z=1 at DECODE, Z=0 at EXEC -> LoadPC=1, SelPC=0, IncPC=0; repeat with Z=0 at DECODE -> IncPC=1, LoadPC=0.
REQ-036 Opcode=1111 -> halted=1, strobes 0 for 10 cycles with run=0; run=1 -> state 001 next cycle.
REQ-037 CNTW=2, 5 ADD instructions -> instr_count 1,2,3,3,3.
REQ-038 CLB pulsed low mid-EXEC of 0101 -> LoadReg drops to 0 immediately, state 000, instr_count 0.
